// File: rtl/rf_bank_scheduler_pkg.sv
// rf_bank_scheduler_pkg
// Shared constants and helpers for the register-file bank scheduler.
// Register addresses are REG_W bits: the low BANK_W bits select the bank,
// the remaining ROW_W bits select the row inside that bank.
package rf_bank_scheduler_pkg;

  localparam int NUM_BANKS = 4;
  localparam int ROW_W     = 3;
  localparam int REG_W     = 5;
  localparam int BANK_W    = 2;
  localparam int BANK_LSB  = 0;
  localparam int ROW_LSB   = 2;

  typedef logic [REG_W-1:0] reg_addr_t;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_PEND = 1'b1
  } slot_state_e;

  function automatic logic [BANK_W-1:0] bank_of(input reg_addr_t a);
    return a[BANK_LSB +: BANK_W];
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input reg_addr_t a);
    return a[ROW_LSB +: ROW_W];
  endfunction

endpackage

// File: rtl/rf_bank_scheduler_rr_arbiter.sv
// rr_arbiter
// Round-robin pick over N requesters. The search starts at ptr and wraps,
// so the requester at ptr has top priority this cycle.
// Ports:
//   req  in  N      request vector
//   ptr  in  IDX_W  index with highest priority
//   gnt  out N      one-hot grant (zero when no request)
//   idx  out IDX_W  index of the granted requester
//   any  out 1      at least one request present
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int pos;
    pos = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/rf_bank_scheduler.sv
// rf_bank_scheduler
// Schedules all accesses to a 4-bank single-port register file: operand
// reads for collector slots and writeback writes. Per bank and cycle at
// most one access is granted; writeback wins unless the bank's read side
// has been blocked for STARVE_LIMIT cycles in a row.
// Ports:
//   clk, rst            clock, async active-high reset
//   alloc_*             new instruction offer / slot handshake
//   wb_valid/addr/ready writeback request and acceptance
//   rf_we/rf_re/rf_addr per-bank RAM controls (3-bit row per bank)
//   oc_valid/slot/src   registered read grant, aligned with RAM data
//   slot_busy           per-slot operands outstanding
module rf_bank_scheduler
  import rf_bank_scheduler_pkg::*;
#(
  parameter int N_SLOT       = 4,
  parameter int SLOT_W       = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic                          alloc_src1_valid,
  input  logic [REG_W-1:0]              alloc_src1_addr,
  input  logic                          alloc_src2_valid,
  input  logic [REG_W-1:0]              alloc_src2_addr,
  output logic [SLOT_W-1:0]             alloc_slot,
  input  logic                          wb_valid,
  input  logic [REG_W-1:0]              wb_addr,
  output logic                          wb_ready,
  output logic [NUM_BANKS-1:0]          rf_we,
  output logic [NUM_BANKS-1:0]          rf_re,
  output logic [NUM_BANKS*ROW_W-1:0]    rf_addr,
  output logic [NUM_BANKS-1:0]          oc_valid,
  output logic [NUM_BANKS*SLOT_W-1:0]   oc_slot,
  output logic [NUM_BANKS-1:0]          oc_src,
  output logic [N_SLOT-1:0]             slot_busy
);

  localparam int N_REQ = 2 * N_SLOT;
  localparam int IDX_W = SLOT_W + 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // pend_q[s][0] = src1 outstanding, pend_q[s][1] = src2 outstanding
  logic [1:0]        pend_q   [N_SLOT];
  logic [1:0]        pend_d   [N_SLOT];
  reg_addr_t         src_addr [N_SLOT][2];
  logic [IDX_W-1:0]  ptr_q    [NUM_BANKS];
  logic [CNT_W-1:0]  cnt_q    [NUM_BANKS];

  slot_state_e       slot_state [N_SLOT];
  logic [N_REQ-1:0]  req  [NUM_BANKS];
  logic [N_REQ-1:0]  gnt  [NUM_BANKS];
  logic [IDX_W-1:0]  gidx [NUM_BANKS];
  logic [NUM_BANKS-1:0] any_req, starve, wb_take, rd_gnt;
  logic [BANK_W-1:0] wb_bank;
  logic              accept;

  always_comb begin
    for (int s = 0; s < N_SLOT; s++) begin
      slot_state[s] = (pend_q[s] != 2'b00) ? SLOT_PEND : SLOT_IDLE;
      slot_busy[s]  = (slot_state[s] == SLOT_PEND);
    end
  end

  // Lowest idle slot wins; scanning downwards leaves the lowest index last.
  always_comb begin
    alloc_ready = 1'b0;
    alloc_slot  = '0;
    for (int s = N_SLOT - 1; s >= 0; s--) begin
      if (slot_state[s] == SLOT_IDLE) begin
        alloc_ready = 1'b1;
        alloc_slot  = SLOT_W'(s);
      end
    end
  end

  // An offer with no operands to read never occupies a slot.
  assign accept = alloc_valid && alloc_ready && (alloc_src1_valid || alloc_src2_valid);

  assign wb_bank  = bank_of(wb_addr);
  assign wb_ready = !starve[wb_bank];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      starve[b]  = (cnt_q[b] == CNT_W'(STARVE_LIMIT));
      wb_take[b] = wb_valid && wb_ready && (wb_bank == BANK_W'(b));
      for (int s = 0; s < N_SLOT; s++) begin
        for (int r = 0; r < 2; r++) begin
          req[b][s*2+r] = pend_q[s][r] && (bank_of(src_addr[s][r]) == BANK_W'(b));
        end
      end
    end
  end

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    rr_arbiter #(
      .N    (N_REQ),
      .IDX_W(IDX_W)
    ) u_arb (
      .req(req[gb]),
      .ptr(ptr_q[gb]),
      .gnt(gnt[gb]),
      .idx(gidx[gb]),
      .any(any_req[gb])
    );
  end

  // A write on a bank takes its single port, so the read waits.
  always_comb begin
    rf_addr = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_gnt[b] = any_req[b] && !wb_take[b];
      if (wb_take[b]) begin
        rf_addr[b*ROW_W +: ROW_W] = row_of(wb_addr);
      end else if (rd_gnt[b]) begin
        rf_addr[b*ROW_W +: ROW_W] = row_of(src_addr[gidx[b][IDX_W-1:1]][gidx[b][0]]);
      end
    end
  end

  assign rf_we = wb_take;
  assign rf_re = rd_gnt;

  // Only idle slots are allocated, so the clear and set never overlap.
  always_comb begin
    for (int s = 0; s < N_SLOT; s++) begin
      pend_d[s] = pend_q[s];
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rd_gnt[b] && gnt[b][i]) begin
          pend_d[i/2][i%2] = 1'b0;
        end
      end
    end
    if (accept) begin
      pend_d[alloc_slot] = {alloc_src2_valid, alloc_src1_valid};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_SLOT; s++) begin
        pend_q[s]      <= '0;
        src_addr[s][0] <= '0;
        src_addr[s][1] <= '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        ptr_q[b] <= '0;
        cnt_q[b] <= '0;
      end
      oc_valid <= '0;
      oc_slot  <= '0;
      oc_src   <= '0;
    end else begin
      for (int s = 0; s < N_SLOT; s++) begin
        pend_q[s] <= pend_d[s];
      end
      if (accept) begin
        src_addr[alloc_slot][0] <= alloc_src1_addr;
        src_addr[alloc_slot][1] <= alloc_src2_addr;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_gnt[b]) begin
          ptr_q[b] <= gidx[b] + 1'b1;   // wraps naturally, N_REQ is a power of 2
        end
        // With candidates present and no read, the writeback must have taken
        // the port, so only that case counts up.
        if (rd_gnt[b] || !any_req[b]) begin
          cnt_q[b] <= '0;
        end else if (!starve[b]) begin
          cnt_q[b] <= cnt_q[b] + 1'b1;
        end
        oc_valid[b]                <= rd_gnt[b];
        oc_slot[b*SLOT_W +: SLOT_W] <= rd_gnt[b] ? gidx[b][IDX_W-1:1] : '0;
        oc_src[b]                  <= rd_gnt[b] && gidx[b][0];
      end
    end
  end

endmodule
